systolic_seq_ctrl: RTL and testbench

//  Sequencer for systolic_top: loads one kernel into selected PE columns, streams k_len skewed feature rows,

---
 rtl/systolic_seq_pkg.sv | 25 ++
 rtl/systolic_skew_mask.sv | 23 ++
 rtl/systolic_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_pkg.sv
// Shared types and defaults for the systolic array sequencer.
// Optional feature macro: SYSTOLIC_SEQ_PERF_EN (adds a pass-length cycle counter port).
package systolic_seq_pkg;

  localparam int ROW_DEF       = 32;
  localparam int COL_DEF       = 32;
  localparam int KDIM_W_DEF    = 5;
  localparam int LEN_W_DEF     = 16;
  localparam int DRAIN_MAX_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [COL_DEF-1:0]    col_mask;
    logic [KDIM_W_DEF-1:0] k_len;
    logic [LEN_W_DEF-1:0]  fm_len;
  } cfg_t;

endpackage

// File: rtl/systolic_skew_mask.sv
// Row-skew valid mask: row r carries pixel (f_col - r), valid only inside [0, fm_len)
// and only for rows the kernel actually uses. Purely combinational; parent registers it.
module systolic_skew_mask #(
  parameter int ROW    = 32,
  parameter int KDIM_W = 5,
  parameter int LEN_W  = 16
) (
  input  logic [LEN_W:0]    f_col,
  input  logic [KDIM_W-1:0] k_len,
  input  logic [LEN_W-1:0]  fm_len,
  output logic [ROW-1:0]    row_valid
);

  // One valid bit per row from the skewed pixel index.
  always_comb begin
    row_valid = '0;
    for (int r = 0; r < ROW; r++) begin
      if ((r < int'(k_len)) && (int'(f_col) >= r) && ((int'(f_col) - r) < int'(fm_len)))
        row_valid[r] = 1'b1;
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for systolic_top: weight load, skewed feature streaming, result drain.
// Optional feature macro: SYSTOLIC_SEQ_PERF_EN adds perf_cycles (cycles per pass).
//
//   state  | meaning
//   IDLE   | waiting for start; config checked and latched here
//   LOAD_W | one weight tap per cycle into the masked columns
//   STREAM | skewed feature rows, f_col = 0 .. fm_len+k_len-2
//   DRAIN  | waiting for remaining results, bounded by DRAIN_MAX idle cycles
//   DONE   | single-cycle completion pulse
module systolic_seq_ctrl
  import systolic_seq_pkg::*;
#(
  parameter int ROW       = ROW_DEF,
  parameter int COL       = COL_DEF,
  parameter int KDIM_W    = KDIM_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [COL-1:0]    col_mask,
  input  logic [KDIM_W-1:0] k_len,
  input  logic [LEN_W-1:0]  fm_len,
  input  logic              conv_finish,
  output logic [COL-1:0]    weight_en,
  output logic [KDIM_W-1:0] weight_dim,
  output logic              conv_ctrl,
  output logic              w_rd_en,
  output logic [KDIM_W-1:0] w_addr,
  output logic [LEN_W-1:0]  f_col,
  output logic [ROW-1:0]    row_valid,
  output logic [LEN_W-1:0]  res_cnt,
`ifdef SYSTOLIC_SEQ_PERF_EN
  output logic [LEN_W-1:0]  perf_cycles,
`endif
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              cfg_err
);

  localparam int IDLE_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_MAX - 1);
  localparam logic [KDIM_W-1:0] K_ONE     = 1;
  localparam logic [LEN_W-1:0]  L_ONE     = 1;
  localparam logic [LEN_W:0]    S_ONE     = 1;
  localparam logic [LEN_W:0]    S_TWO     = 2;

  seq_state_t        state;
  cfg_t              cfg_q;
  logic [LEN_W:0]    stream_cnt;   // one bit wider so fm_len+k_len-2 never wraps
  logic [LEN_W:0]    stream_last;
  logic [LEN_W:0]    rv_f;
  logic [ROW-1:0]    rv_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic              cfg_bad;

  assign cfg_bad = (k_len == '0) || (int'(k_len) > ROW) || (fm_len == '0) || (col_mask == '0);

  assign stream_last = {1'b0, cfg_q.fm_len} + (LEN_W+1)'(cfg_q.k_len) - S_TWO;

  // Mask is computed for the f_col value being loaded this edge, so row_valid lines up with f_col.
  assign rv_f = (state == STREAM) ? (stream_cnt + S_ONE) : '0;

  assign f_col = stream_cnt[LEN_W-1:0];

  systolic_skew_mask #(
    .ROW    (ROW),
    .KDIM_W (KDIM_W),
    .LEN_W  (LEN_W)
  ) u_skew (
    .f_col     (rv_f),
    .k_len     (cfg_q.k_len),
    .fm_len    (cfg_q.fm_len),
    .row_valid (rv_next)
  );

  // Pass sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cfg_q      <= '0;
      stream_cnt <= '0;
      idle_cnt   <= '0;
      weight_en  <= '0;
      weight_dim <= '0;
      conv_ctrl  <= 1'b0;
      w_rd_en    <= 1'b0;
      w_addr     <= '0;
      row_valid  <= '0;
      res_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_q.col_mask <= col_mask;
              cfg_q.k_len    <= k_len;
              cfg_q.fm_len   <= fm_len;
              weight_dim     <= k_len;
              timeout        <= 1'b0;
              res_cnt        <= '0;
              stream_cnt     <= '0;
              w_addr         <= '0;
              w_rd_en        <= 1'b1;
              weight_en      <= col_mask;
              conv_ctrl      <= (k_len == K_ONE);
              busy           <= 1'b1;
              state          <= LOAD_W;
            end
          end
        end
        LOAD_W: begin
          if (w_addr == cfg_q.k_len - K_ONE) begin
            weight_en  <= '0;
            w_rd_en    <= 1'b0;
            conv_ctrl  <= 1'b1;
            stream_cnt <= '0;
            row_valid  <= rv_next;
            state      <= STREAM;
          end else begin
            weight_en <= cfg_q.col_mask;
            w_addr    <= w_addr + K_ONE;
            conv_ctrl <= ((w_addr + K_ONE) == (cfg_q.k_len - K_ONE));
          end
        end
        STREAM: begin
          if (stream_cnt == stream_last) begin
            row_valid <= '0;
            idle_cnt  <= '0;
            state     <= DRAIN;
          end else begin
            stream_cnt <= stream_cnt + S_ONE;
            row_valid  <= rv_next;
          end
        end
        DRAIN: begin
          // Completion is checked first so a full result count never reports a timeout.
          if (res_cnt == cfg_q.fm_len) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (!conv_finish && (idle_cnt == IDLE_LAST)) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else if (conv_finish) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DONE: begin
          conv_ctrl <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (((state == STREAM) || (state == DRAIN)) && conv_finish && (res_cnt != cfg_q.fm_len))
        res_cnt <= res_cnt + L_ONE;
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_EN
  // Counts every non-IDLE cycle of a pass, saturating; cleared when a pass is accepted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cycles <= '0;
    end else if (state == IDLE) begin
      if (start && !cfg_bad)
        perf_cycles <= '0;
    end else if (perf_cycles != '1) begin
      perf_cycles <= perf_cycles + L_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed + randomized bench for systolic_seq_ctrl. Expected behaviour is derived per
// cycle from the pass timeline (load taps, skewed pixels, result count, drain bound).
module tb_systolic_seq_ctrl;
  import systolic_seq_pkg::*;

  localparam int ROW       = 32;
  localparam int COL       = 32;
  localparam int KDIM_W    = 5;
  localparam int LEN_W     = 16;
  localparam int DRAIN_MAX = 255;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              start = 1'b0;
  logic [COL-1:0]    col_mask = '0;
  logic [KDIM_W-1:0] k_len = '0;
  logic [LEN_W-1:0]  fm_len = '0;
  logic              conv_finish = 1'b0;
  logic [COL-1:0]    weight_en;
  logic [KDIM_W-1:0] weight_dim;
  logic              conv_ctrl;
  logic              w_rd_en;
  logic [KDIM_W-1:0] w_addr;
  logic [LEN_W-1:0]  f_col;
  logic [ROW-1:0]    row_valid;
  logic [LEN_W-1:0]  res_cnt;
`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [LEN_W-1:0]  perf_cycles;
`endif
  logic              busy;
  logic              done;
  logic              timeout;
  logic              cfg_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(
    .ROW(ROW), .COL(COL), .KDIM_W(KDIM_W), .LEN_W(LEN_W), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .col_mask    (col_mask),
    .k_len       (k_len),
    .fm_len      (fm_len),
    .conv_finish (conv_finish),
    .weight_en   (weight_en),
    .weight_dim  (weight_dim),
    .conv_ctrl   (conv_ctrl),
    .w_rd_en     (w_rd_en),
    .w_addr      (w_addr),
    .f_col       (f_col),
    .row_valid   (row_valid),
    .res_cnt     (res_cnt),
`ifdef SYSTOLIC_SEQ_PERF_EN
    .perf_cycles (perf_cycles),
`endif
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cfg_err     (cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Row r of a k-tap kernel reads pixel f-r; valid when that pixel exists in the row.
  function automatic logic [ROW-1:0] exp_rv(input int f, input int k, input int fm);
    logic [ROW-1:0] v;
    v = '0;
    for (int r = 0; r < k; r++) begin
      int p;
      p = f - r;
      if (p >= 0 && p < fm) v[r] = 1'b1;
    end
    return v;
  endfunction

  task automatic run_pass(input int k, input int fm, input logic [COL-1:0] m,
                          input int cf_pct, input bit hold, input int abort_f);
    int  t, exp_res, idle_run, done_at, budget, span;
    bit  exp_to, finished, cf, counted;
    t = 1; exp_res = 0; idle_run = 0; done_at = -1; exp_to = 0; finished = 0;
    span   = fm + k - 1;
    budget = 20000;
    @(negedge clk);
    start = 1'b1; k_len = KDIM_W'(k); fm_len = LEN_W'(fm); col_mask = m; conv_finish = 1'b0;
    @(negedge clk);
    if (!hold) start = 1'b0;
    while (!finished && t <= budget) begin
      if (hold) begin
        k_len = KDIM_W'($urandom); fm_len = LEN_W'($urandom); col_mask = COL'($urandom);
      end
      cf = ($urandom_range(99) < cf_pct);
      counted = 0;
      if (t <= k) begin
        chk("load_wen", weight_en, m);
        chk("load_ctl", {w_rd_en, w_addr, conv_ctrl, busy, done, timeout},
            {1'b1, KDIM_W'(t - 1), (t == k), 1'b1, 1'b0, 1'b0});
        chk("load_dim", weight_dim, k);
        chk("load_rv", row_valid, 0);
      end else if (t <= k + span) begin
        chk("stream_fcol", f_col, t - k - 1);
        chk("stream_rv", row_valid, exp_rv(t - k - 1, k, fm));
        chk("stream_ctl", {weight_en != '0, w_rd_en, conv_ctrl, busy, done}, 5'b00110);
        counted = 1;
      end else if (done_at < 0) begin
        chk("drain_ctl", {row_valid != '0, conv_ctrl, busy, done}, 4'b0110);
        counted = 1;
        if (exp_res == fm) done_at = t + 1;
        else if (!cf && idle_run + 1 == DRAIN_MAX) begin done_at = t + 1; exp_to = 1; end
        else idle_run = cf ? 0 : idle_run + 1;
      end else if (t == done_at) begin
        chk("done_pulse", {done, busy, timeout}, {1'b1, 1'b1, exp_to});
        if (hold) start = 1'b0;
      end else begin
        chk("after_done", {done, busy, conv_ctrl, timeout}, {1'b0, 1'b0, 1'b0, exp_to});
`ifdef SYSTOLIC_SEQ_PERF_EN
        chk("perf", perf_cycles, done_at);
`endif
        cf = 0;
        finished = 1;
      end
      chk("res_cnt", res_cnt, exp_res);
      conv_finish = cf;
      if (counted && cf && exp_res < fm) exp_res++;
      if (abort_f >= 0 && t == k + 1 + abort_f) begin
        #2 nrst = 1'b0;
        #1;
        chk("rst_outs_a", {weight_en, weight_dim, conv_ctrl, w_rd_en, w_addr, f_col}, 0);
        chk("rst_outs_b", {row_valid, res_cnt, busy, done, timeout, cfg_err}, 0);
        conv_finish = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        finished = 1;
      end
      if (!finished) begin
        @(negedge clk);
        t++;
      end
    end
    conv_finish = 1'b0;
    chk("pass_end", finished, 1);
  endtask

  task automatic bad_cfg(input int k, input int fm, input logic [COL-1:0] m);
    @(negedge clk);
    start = 1'b1; k_len = KDIM_W'(k); fm_len = LEN_W'(fm); col_mask = m;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_hi", {cfg_err, busy, weight_en != '0, w_rd_en}, 4'b1000);
    @(negedge clk);
    chk("cfg_err_lo", {cfg_err, busy, weight_en != '0}, 3'b000);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_a", {weight_en, weight_dim, conv_ctrl, w_rd_en, w_addr, f_col}, 0);
    chk("reset_b", {row_valid, res_cnt, busy, done, timeout, cfg_err}, 0);
    nrst = 1'b1;
    @(negedge clk);

    run_pass(25, 784, 32'h3, 50, 0, -1);
    bad_cfg(0, 8, 32'h1);
    bad_cfg(3, 0, 32'h1);
    bad_cfg(3, 8, 32'h0);
    run_pass(1, 4, 32'h1, 100, 0, -1);
    run_pass(3, 8, 32'h5, 0, 0, -1);
    run_pass(5, 20, 32'hff, 30, 0, 10);
    run_pass(4, 6, 32'h1, 60, 0, -1);
    run_pass(7, 12, 32'hf0f0, 90, 1, -1);
    for (int i = 0; i < 4; i++) begin
      logic [COL-1:0] m;
      m = COL'($urandom) | COL'(1);
      run_pass($urandom_range(1, 31), $urandom_range(1, 40), m, $urandom_range(0, 100), 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
